memdump: RTL



---
 rtl/memdump_if.sv | 31 +++
 rtl/memdump.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/memdump_if.sv
`default_nettype none
// ============================================================================
// memdump_if : CSR window, memory-master and UART byte-stream signals
// Rev 1.0
// ============================================================================
interface memdump_if;
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;
    logic [31:0] a_mem;
    logic        rd_mem;
    logic [31:0] spo_mem;
    logic        ready_mem;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        irq;

    modport master (
        input  a, d, we, spo_mem, ready_mem, tx_ready,
        output spo, a_mem, rd_mem, tx_data, tx_valid, busy, irq
    );

    modport slave (
        output a, d, we, spo_mem, ready_mem, tx_ready,
        input  spo, a_mem, rd_mem, tx_data, tx_valid, busy, irq
    );
endinterface
`default_nettype wire

// File: rtl/memdump.sv
`default_nettype none
// ============================================================================
// memdump : reads BASE..BASE+4*COUNT-1 and streams the words out LSB first
//           optional trailing checksum byte: MEMDUMP_CHECKSUM_EN
// Rev 1.0
// ============================================================================
module memdump #(
    parameter int ADDR_ALIGN  = 2,
    parameter int MAX_COUNT_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    memdump_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [31:0]            C_STEP       = 32'd1 << ADDR_ALIGN;
    localparam logic [31:0]            C_ALIGN_MASK = ~(C_STEP - 32'd1);
    localparam logic [MAX_COUNT_W-1:0] C_ONE        = MAX_COUNT_W'(1);

`ifdef MEMDUMP_CHECKSUM_EN
    localparam logic       C_CSUM_EN    = 1'b1;
    localparam logic [2:0] C_AFTER_DATA = S_CSUM;
`else
    localparam logic       C_CSUM_EN    = 1'b0;
    localparam logic [2:0] C_AFTER_DATA = S_FIN;
`endif

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [31:0]            r_base;
    logic [MAX_COUNT_W-1:0] r_count;
    logic [31:0]            r_cur_addr;
    logic [MAX_COUNT_W-1:0] r_remaining;
    logic [31:0]            r_word;
    logic [1:0]             r_byte_idx;
    logic [7:0]             r_csum;
    logic                   r_done;

    logic       w_busy;
    logic       w_rd;
    logic       w_tx_valid;
    logic       w_tx_fire;
    logic [7:0] w_data_byte;
    logic       w_ctrl_wr;
    logic       w_start;
    logic       w_abort;

    assign w_ctrl_wr = bus.we && (bus.a == 3'd2);
    assign w_start   = w_ctrl_wr && bus.d[0] && (r_state == S_IDLE);
    assign w_abort   = w_ctrl_wr && bus.d[1] && w_busy;
    assign w_tx_fire = w_tx_valid && bus.tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A zero-length dump still spends one busy cycle in REQ, with the read suppressed
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_REQ;
            S_REQ: begin
                if (r_remaining == '0)  w_next = S_FIN;
                else if (bus.ready_mem) w_next = S_SEND;
            end
            S_SEND: begin
                if (w_tx_fire && (r_byte_idx == 2'd3))
                    w_next = (r_remaining == C_ONE) ? C_AFTER_DATA : S_REQ;
            end
            S_CSUM: if (w_tx_fire) w_next = S_FIN;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_comb begin
        w_busy     = (r_state != S_IDLE) && (r_state != S_FIN);
        w_rd       = (r_state == S_REQ) && (r_remaining != '0);
        w_tx_valid = (r_state == S_SEND) || (r_state == S_CSUM);
        case (r_byte_idx)
            2'd0:    w_data_byte = r_word[7:0];
            2'd1:    w_data_byte = r_word[15:8];
            2'd2:    w_data_byte = r_word[23:16];
            default: w_data_byte = r_word[31:24];
        endcase

        bus.busy     = w_busy;
        bus.irq      = (r_state == S_FIN);
        bus.rd_mem   = w_rd;
        bus.a_mem    = w_rd ? r_cur_addr : 32'd0;
        bus.tx_valid = w_tx_valid;
        if (r_state == S_SEND)      bus.tx_data = w_data_byte;
        else if (r_state == S_CSUM) bus.tx_data = 8'd0 - r_csum;
        else                        bus.tx_data = 8'd0;

        case (bus.a)
            3'd0:    bus.spo = r_base;
            3'd1:    bus.spo = 32'(r_count);
            3'd3:    bus.spo = {29'd0, C_CSUM_EN, r_done, w_busy};
            3'd4:    bus.spo = r_cur_addr;
            default: bus.spo = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base      <= '0;
            r_count     <= '0;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_word      <= '0;
            r_byte_idx  <= '0;
            r_csum      <= '0;
            r_done      <= 1'b0;
        end else begin
            if (bus.we && (bus.a == 3'd0)) r_base  <= bus.d & C_ALIGN_MASK;
            if (bus.we && (bus.a == 3'd1)) r_count <= bus.d[MAX_COUNT_W-1:0];
            if (w_start) begin
                r_cur_addr  <= r_base;
                r_remaining <= r_count;
                r_done      <= 1'b0;
                r_csum      <= '0;
            end
            if ((r_state == S_REQ) && bus.ready_mem) begin
                r_word     <= bus.spo_mem;
                r_byte_idx <= 2'd0;
            end
            if ((r_state == S_SEND) && w_tx_fire) begin
                r_csum     <= r_csum + w_data_byte;
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd3) begin
                    r_remaining <= r_remaining - C_ONE;
                    r_cur_addr  <= r_cur_addr + C_STEP;
                end
            end
            if ((w_next == S_FIN) && (r_state != S_FIN)) r_done <= 1'b1;
        end
    end
endmodule
`default_nettype wire
